// File: rtl/deserializer_1to64_sr_if.sv
// Serial receive link bundle: bit-slot inputs toward the deserializer, parallel word back out.
// Latency: none (wires only).
// Backpressure: none; the link is strobe driven (bit_en), the core must accept every data_valid.
interface deserializer_1to64_sr_if #(
  parameter int WIDTH = 64
);
  logic             frame_start;
  logic             bit_en;
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;

  // Serial source side: drives bit slots, observes the received word.
  modport master (
    output frame_start, bit_en, data_in,
    input  data_out, data_valid, busy, frame_err
  );

  // Deserializer side.
  modport slave (
    input  frame_start, bit_en, data_in,
    output data_out, data_valid, busy, frame_err
  );
endinterface

// File: rtl/deserializer_1to64_sr.sv
// Serial-to-parallel receiver: collects WIDTH bits MSB first from a frame_start marker.
// Latency: data_out/data_valid update on the edge that samples the WIDTH-th bit.
// Backpressure: none; bit_en=0 slots freeze all state, a new frame_start mid-word restarts it.
module deserializer_1to64_sr #(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  deserializer_1to64_sr_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state logic: bit slots drive the frame FSM; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          // Bits outside a frame are dropped until a start marker shows up.
          if (bus.frame_start) begin
            shift_d = {{(WIDTH-1){1'b0}}, bus.data_in};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.frame_start) begin
            // Early start marker: throw away the partial word and begin again from this bit.
            err_d   = 1'b1;
            shift_d = {{(WIDTH-1){1'b0}}, bus.data_in};
            cnt_d   = CW'(1);
          end else begin
            shift_d = {shift_q[WIDTH-2:0], bus.data_in};
            if (cnt_q == CW'(WIDTH - 1)) begin
              data_out_d = shift_d;
              valid_d    = 1'b1;
              cnt_d      = '0;
              state_d    = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_deserializer_1to64_sr.sv
// Bench for deserializer_1to64_sr: directed frames plus random slots against a bit-queue model.
module tb_deserializer_1to64_sr;
  logic clk = 1'b0;
  logic reset;

  deserializer_1to64_sr_if #(.WIDTH(64)) bus ();

  deserializer_1to64_sr #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is just the list of bits seen since the last start marker.
  bit          mq[$];
  bit          m_in;
  logic [63:0] m_dout;
  bit          m_valid;
  bit          m_err;

  task automatic step(input bit rst, input bit fs, input bit en, input bit d);
    @(negedge clk);
    reset           = rst;
    bus.frame_start = fs;
    bus.bit_en      = en;
    bus.data_in     = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_in = 0; m_dout = '0; m_valid = 0; m_err = 0;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (en) begin
        if (fs) begin
          if (m_in) m_err = 1;
          mq.delete();
          mq.push_back(d);
          m_in = 1;
        end else if (m_in) begin
          mq.push_back(d);
          if (mq.size() == 64) begin
            m_dout = '0;
            foreach (mq[i]) m_dout = {m_dout[62:0], mq[i]};
            m_valid = 1;
            m_in    = 0;
            mq.delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    total++;
    if (bus.data_out !== 64'h0) begin
      bad++; $display("FAIL reset_dout: got %h expected 0", bus.data_out);
    end
    total++;
    if ({bus.data_valid, bus.busy, bus.frame_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got v/b/e=%b%b%b expected 000", bus.data_valid, bus.busy, bus.frame_err);
    end
  endtask

  task automatic test_single_word();
    logic [63:0] w = 64'hDEAD_BEEF_0123_4567;
    int pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, i == 0, 1, w[63-i]);
      if (bus.data_valid) pulses++;
      total++;
      if ({bus.data_out, bus.data_valid, bus.busy, bus.frame_err} !== {m_dout, m_valid, m_in, m_err}) begin
        bad++;
        $display("FAIL single_word bit %0d: got dout=%h v=%b b=%b e=%b expected dout=%h v=%b b=%b e=%b",
                 i, bus.data_out, bus.data_valid, bus.busy, bus.frame_err, m_dout, m_valid, m_in, m_err);
      end
      total++;
      if (bus.busy !== (i < 63)) begin
        bad++; $display("FAIL single_word_busy bit %0d: got %b expected %b", i, bus.busy, (i < 63));
      end
    end
    total++;
    if (bus.data_out !== 64'hDEAD_BEEF_0123_4567 || pulses != 1) begin
      bad++; $display("FAIL single_word_final: got dout=%h pulses=%0d expected DEADBEEF01234567 pulses=1", bus.data_out, pulses);
    end
  endtask

  task automatic test_gapped();
    logic [63:0] w = 64'hDEAD_BEEF_0123_4567;
    int pulses = 0;
    for (int i = 0; i < 64; i++) begin
      for (int g = 0; g < 3; g++) begin
        if (g == 0) step(0, i == 0, 1, w[63-i]);
        else        step(0, 1'($urandom), 0, 1'($urandom));
        if (bus.data_valid) pulses++;
        total++;
        if ({bus.data_out, bus.data_valid, bus.busy, bus.frame_err} !== {m_dout, m_valid, m_in, m_err}) begin
          bad++;
          $display("FAIL gapped bit %0d slot %0d: got dout=%h v=%b b=%b e=%b expected dout=%h v=%b b=%b e=%b",
                   i, g, bus.data_out, bus.data_valid, bus.busy, bus.frame_err, m_dout, m_valid, m_in, m_err);
        end
      end
    end
    total++;
    if (bus.data_out !== 64'hDEAD_BEEF_0123_4567 || pulses != 1) begin
      bad++; $display("FAIL gapped_final: got dout=%h pulses=%0d expected DEADBEEF01234567 pulses=1", bus.data_out, pulses);
    end
  endtask

  task automatic test_frame_err();
    logic [63:0] w = 64'h0F0F_0F0F_0F0F_0F0F;
    int errs = 0;
    for (int i = 0; i < 20; i++) step(0, i == 0, 1, 1'($urandom));
    for (int i = 0; i < 64; i++) begin
      step(0, i == 0, 1, w[63-i]);
      if (bus.frame_err) errs++;
      if (i == 0) begin
        total++;
        if (bus.frame_err !== 1'b1) begin
          bad++; $display("FAIL frame_err_pulse: got %b expected 1", bus.frame_err);
        end
      end
      if (i == 62) begin
        total++;
        if (bus.data_out !== 64'hDEAD_BEEF_0123_4567 || bus.data_valid !== 1'b0) begin
          bad++; $display("FAIL frame_err_hold: got dout=%h v=%b expected DEADBEEF01234567 v=0", bus.data_out, bus.data_valid);
        end
      end
      total++;
      if ({bus.data_out, bus.data_valid, bus.busy, bus.frame_err} !== {m_dout, m_valid, m_in, m_err}) begin
        bad++;
        $display("FAIL frame_err bit %0d: got dout=%h v=%b b=%b e=%b expected dout=%h v=%b b=%b e=%b",
                 i, bus.data_out, bus.data_valid, bus.busy, bus.frame_err, m_dout, m_valid, m_in, m_err);
      end
    end
    total++;
    if (bus.data_out !== 64'h0F0F_0F0F_0F0F_0F0F || bus.data_valid !== 1'b1 || errs != 1) begin
      bad++; $display("FAIL frame_err_final: got dout=%h v=%b errs=%0d expected 0F0F0F0F0F0F0F0F v=1 errs=1",
                      bus.data_out, bus.data_valid, errs);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int busy_seen = 0;
    for (int i = 0; i < 30; i++) step(0, i == 0, 1, 1'($urandom));
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    total++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.frame_err} !== {64'h0, 3'b000}) begin
      bad++; $display("FAIL reset_mid: got dout=%h v=%b b=%b e=%b expected all 0",
                      bus.data_out, bus.data_valid, bus.busy, bus.frame_err);
    end
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, 1'($urandom));
      if (bus.data_valid) pulses++;
      if (bus.busy) busy_seen++;
    end
    total++;
    if (pulses != 0 || busy_seen != 0 || bus.data_out !== 64'h0) begin
      bad++; $display("FAIL reset_mid_idle: got pulses=%0d busy=%0d dout=%h expected 0 0 0", pulses, busy_seen, bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w0 = 64'hAAAA_AAAA_AAAA_AAAA;
    logic [63:0] w1 = 64'h5555_5555_5555_5555;
    int vcyc[$];
    logic [63:0] vdat[$];
    int errs = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < 64) step(0, i == 0, 1, w0[63-i]);
      else        step(0, i == 64, 1, w1[127-i]);
      if (bus.data_valid) begin vcyc.push_back(i); vdat.push_back(bus.data_out); end
      if (bus.frame_err) errs++;
    end
    total++;
    if (vcyc.size() != 2 || errs != 0) begin
      bad++; $display("FAIL b2b_count: got pulses=%0d errs=%0d expected 2 0", vcyc.size(), errs);
    end else begin
      total++;
      if (vcyc[1] - vcyc[0] != 64 || vcyc[0] != 63) begin
        bad++; $display("FAIL b2b_spacing: got first=%0d gap=%0d expected 63 64", vcyc[0], vcyc[1] - vcyc[0]);
      end
      total++;
      if (vdat[0] !== 64'hAAAA_AAAA_AAAA_AAAA || vdat[1] !== 64'h5555_5555_5555_5555) begin
        bad++; $display("FAIL b2b_data: got %h %h expected AAAAAAAAAAAAAAAA 5555555555555555", vdat[0], vdat[1]);
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 3) != 0, 1'($urandom));
      total++;
      if ({bus.data_out, bus.data_valid, bus.busy, bus.frame_err} !== {m_dout, m_valid, m_in, m_err}) begin
        errs++;
        bad++;
        if (errs <= 10)
          $display("FAIL random cyc %0d: got dout=%h v=%b b=%b e=%b expected dout=%h v=%b b=%b e=%b",
                   i, bus.data_out, bus.data_valid, bus.busy, bus.frame_err, m_dout, m_valid, m_in, m_err);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.bit_en      = 1'b0;
    bus.data_in     = 1'b0;
    test_reset();
    test_single_word();
    test_gapped();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
